// File: rtl/led_pkg.sv
// Shared colour/mode encodings and the colour helpers used by the RGB sequencer.
package led_pkg;

    typedef enum logic [1:0] {
        C_RED   = 2'b00,
        C_GREEN = 2'b01,
        C_BLUE  = 2'b10,
        C_ERROR = 2'b11
    } color_t;

    typedef enum logic [1:0] {
        M_IDLE  = 2'b00,
        M_RUN   = 2'b01,
        M_PAUSE = 2'b10
    } mode_t;

    // Active-low {R,G,B} mask; the error colour lights everything.
    function automatic logic [2:0] color_to_rgb(input color_t c);
        logic [2:0] mask;
        case (c)
            C_RED:   mask = 3'b011;
            C_GREEN: mask = 3'b101;
            C_BLUE:  mask = 3'b110;
            default: mask = 3'b000;
        endcase
        return mask;
    endfunction

    // C_ERROR is sticky: only start or reset leaves it.
    function automatic color_t next_color(input color_t c);
        color_t nxt;
        case (c)
            C_RED:   nxt = C_GREEN;
            C_GREEN: nxt = C_BLUE;
            C_BLUE:  nxt = C_RED;
            default: nxt = C_ERROR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pwm_generator.sv
// Free-running PWM counter with a duty register that only reloads at the start
// of a period, so a brightness change never produces a truncated pulse.
module pwm_generator #(
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                on
);

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;

    always_comb begin
        cnt_d  = cnt_q + PWM_BITS'(1);
        duty_d = duty_q;
        if (cnt_q == '0) begin
            duty_d = brightness;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            duty_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
        end
    end

    assign on = (cnt_q < duty_q);

endmodule

// File: rtl/rgb_sequence_scheduler.sv
// RED->GREEN->BLUE LED sequencer with run/pause/step control and PWM dimming.
//   state   | meaning
//   M_IDLE  | LED dark, waiting for start
//   M_RUN   | dwell counter advances the colour at terminal count
//   M_PAUSE | colour held lit, dwell frozen; step still advances
module rgb_sequence_scheduler
    import led_pkg::*;
#(
    parameter int DWELL_CYCLES = 12_000_000,
    parameter int PWM_BITS     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                pause,
    input  logic                step,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [2:0]          rgb,
    output color_t              color,
    output logic                running,
    output logic                wrap
);

    localparam int DW = $clog2(DWELL_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

    mode_t          mode_q, mode_d;
    color_t         color_q, color_d;
    logic [DW-1:0]  dwell_q, dwell_d;
    logic [2:0]     rgb_q, rgb_d;
    logic           wrap_q, wrap_d;
    logic           advance;
    logic           pwm_on;

    pwm_generator #(.PWM_BITS(PWM_BITS)) u_pwm (
        .clk        (clk),
        .rst        (rst),
        .brightness (brightness),
        .on         (pwm_on)
    );

    // Priority start > pause > step is encoded by the if/else order.
    always_comb begin
        mode_d  = mode_q;
        color_d = color_q;
        dwell_d = dwell_q;
        wrap_d  = 1'b0;
        advance = 1'b0;
        case (mode_q)
            M_IDLE: begin
                if (start) begin
                    mode_d  = M_RUN;
                    color_d = C_RED;
                    dwell_d = '0;
                end
            end
            M_RUN: begin
                if (start) begin
                    color_d = C_RED;
                    dwell_d = '0;
                end else if (pause) begin
                    mode_d = M_PAUSE;
                end else if (step || dwell_q == DWELL_LAST) begin
                    advance = 1'b1;
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            M_PAUSE: begin
                if (start) begin
                    mode_d  = M_RUN;
                    color_d = C_RED;
                    dwell_d = '0;
                end else if (pause) begin
                    mode_d = M_RUN;
                end else if (step) begin
                    advance = 1'b1;
                end
            end
            default: mode_d = M_IDLE;
        endcase

        if (advance) begin
            color_d = next_color(color_q);
            dwell_d = '0;
            wrap_d  = (color_q == C_BLUE);
        end

        if (color_q == C_ERROR) begin
            rgb_d = 3'b000;
        end else if (mode_q != M_IDLE && pwm_on) begin
            rgb_d = color_to_rgb(color_q);
        end else begin
            rgb_d = 3'b111;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q  <= M_IDLE;
            color_q <= C_RED;
            dwell_q <= '0;
            rgb_q   <= 3'b111;
            wrap_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            color_q <= color_d;
            dwell_q <= dwell_d;
            rgb_q   <= rgb_d;
            wrap_q  <= wrap_d;
        end
    end

    assign rgb     = rgb_q;
    assign color   = color_q;
    assign running = (mode_q == M_RUN);
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_rgb_sequence_scheduler.sv
// Directed bench: a per-cycle vector table for the sequencer plus hand-written
// reset and error-colour sequences.
module tb_rgb_sequence_scheduler;
    import led_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       step = 1'b0;
    logic [1:0] brightness = 2'd3;
    logic [2:0] rgb;
    color_t     color;
    logic       running;
    logic       wrap;

    int n_checks = 0;
    int n_errors = 0;

    rgb_sequence_scheduler #(.DWELL_CYCLES(4), .PWM_BITS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause      (pause),
        .step       (step),
        .brightness (brightness),
        .rgb        (rgb),
        .color      (color),
        .running    (running),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st, pa, sp;
        logic [1:0] br;
        logic [1:0] col;
        logic       run, wr;
        logic [2:0] rgb;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic st, input logic pa, input logic sp,
                                input logic [1:0] br, input logic [1:0] col,
                                input logic run, input logic wr, input logic [2:0] exp_rgb);
        vec_t v;
        v.st = st; v.pa = pa; v.sp = sp; v.br = br;
        v.col = col; v.run = run; v.wr = wr; v.rgb = exp_rgb;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %b expected %b", nm, idx, act, exp);
        end
    endtask

    localparam logic [1:0] R = 2'd0, G = 2'd1, B = 2'd2;

    initial begin
        // Run, wrap, pause, step, priority and PWM vectors (one entry per clock).
        add(1,0,0,3, R,1,0,3'b111); add(0,0,0,3, R,1,0,3'b011);
        add(0,0,0,3, R,1,0,3'b011); add(0,0,0,3, R,1,0,3'b111);
        add(0,0,0,3, G,1,0,3'b011); add(0,0,0,3, G,1,0,3'b101);
        add(0,0,0,3, G,1,0,3'b101); add(0,0,0,3, G,1,0,3'b111);
        add(0,0,0,3, B,1,0,3'b101); add(0,0,0,3, B,1,0,3'b110);
        add(0,0,0,3, B,1,0,3'b110); add(0,0,0,3, B,1,0,3'b111);
        add(0,0,0,3, R,1,1,3'b110); add(0,0,0,3, R,1,0,3'b011);
        add(0,0,0,3, R,1,0,3'b011); add(0,0,0,3, R,1,0,3'b111);
        add(0,0,0,3, G,1,0,3'b011); add(0,0,0,3, G,1,0,3'b101);
        add(0,0,0,3, G,1,0,3'b101);
        add(0,1,0,3, G,0,0,3'b111);
        add(0,0,0,3, G,0,0,3'b101); add(0,0,0,3, G,0,0,3'b101);
        add(0,0,0,3, G,0,0,3'b101); add(0,0,0,3, G,0,0,3'b111);
        add(0,0,0,3, G,0,0,3'b101); add(0,0,0,3, G,0,0,3'b101);
        add(0,0,0,3, G,0,0,3'b101); add(0,0,0,3, G,0,0,3'b111);
        add(0,0,0,3, G,0,0,3'b101); add(0,0,0,3, G,0,0,3'b101);
        add(0,1,0,3, G,1,0,3'b101);
        add(0,0,0,3, G,1,0,3'b111); add(0,0,0,3, B,1,0,3'b101);
        add(0,1,0,3, B,0,0,3'b110);
        add(0,0,1,3, R,0,1,3'b110);
        add(0,1,0,3, R,1,0,3'b111); add(0,0,0,3, R,1,0,3'b011);
        add(1,1,1,3, R,1,0,3'b011);
        add(0,0,0,3, R,1,0,3'b011); add(0,0,0,3, R,1,0,3'b111);
        add(0,0,0,3, R,1,0,3'b011); add(0,0,0,3, G,1,0,3'b011);
        add(0,0,0,3, G,1,0,3'b101); add(0,0,0,3, G,1,0,3'b111);
        add(0,0,0,3, G,1,0,3'b101);
        add(0,0,1,3, B,1,0,3'b101);
        add(0,0,0,3, B,1,0,3'b110);
        add(1,0,0,3, R,1,0,3'b111);
        add(0,0,0,3, R,1,0,3'b011);
        add(0,0,0,1, R,1,0,3'b011); add(0,0,0,1, R,1,0,3'b011);
        add(0,0,0,1, G,1,0,3'b111); add(0,0,0,1, G,1,0,3'b101);
        add(0,0,0,1, G,1,0,3'b111); add(0,0,0,1, G,1,0,3'b111);
        add(0,0,0,1, B,1,0,3'b111); add(0,0,0,1, B,1,0,3'b110);
        add(0,0,0,1, B,1,0,3'b111); add(0,0,0,1, B,1,0,3'b111);
        add(0,0,0,1, R,1,1,3'b111); add(0,0,0,1, R,1,0,3'b011);
        add(0,0,0,0, R,1,0,3'b111); add(0,0,0,0, R,1,0,3'b111);
        add(0,0,0,0, G,1,0,3'b111); add(0,0,0,0, G,1,0,3'b101);
        add(0,0,0,0, G,1,0,3'b111); add(0,0,0,0, G,1,0,3'b111);
        add(0,0,0,0, B,1,0,3'b111); add(0,0,0,0, B,1,0,3'b111);
        add(0,0,0,0, B,1,0,3'b111);

        repeat (3) @(negedge clk);
        chk("rst_rgb", 0, rgb, 3'b111);
        chk("rst_color", 0, 3'(color), 3'(R));
        chk("rst_running", 0, 3'(running), 3'b000);
        chk("rst_wrap", 0, 3'(wrap), 3'b000);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].st; pause = vecs[i].pa; step = vecs[i].sp;
            brightness = vecs[i].br;
            @(posedge clk);
            #1;
            chk("vec_color", i + 1, 3'(color), 3'(vecs[i].col));
            chk("vec_running", i + 1, 3'(running), 3'(vecs[i].run));
            chk("vec_wrap", i + 1, 3'(wrap), 3'(vecs[i].wr));
            chk("vec_rgb", i + 1, rgb, vecs[i].rgb);
            @(negedge clk);
        end

        // Asynchronous reset while running in BLUE.
        start = 1'b0; pause = 1'b0; step = 1'b0; brightness = 2'd3;
        #2 rst = 1'b0;
        #1;
        chk("async_rst_rgb", 0, rgb, 3'b111);
        chk("async_rst_color", 0, 3'(color), 3'(R));
        chk("async_rst_running", 0, 3'(running), 3'b000);
        chk("async_rst_wrap", 0, 3'(wrap), 3'b000);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("idle_rgb", i, rgb, 3'b111);
            chk("idle_running", i, 3'(running), 3'b000);
        end

        // Error colour: all channels lit regardless of PWM, cleared by start.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("err_pre_running", 0, 3'(running), 3'b001);
        @(negedge clk);
        start = 1'b0;
        force dut.color_q = C_ERROR;
        @(posedge clk);
        #1;
        chk("err_color", 0, 3'(color), 3'b011);
        chk("err_rgb", 0, rgb, 3'b000);
        @(negedge clk);
        release dut.color_q;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            chk("err_color", i, 3'(color), 3'b011);
            chk("err_rgb", i, rgb, 3'b000);
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("err_clear_color", 0, 3'(color), 3'(R));
        chk("err_clear_running", 0, 3'(running), 3'b001);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
